adder_bist_checker: RTL and testbench
=====================================

Name: adder_bist_checker

Overview:
- Built-in self-test engine for the registered 4-bit carry-lookahead adder block. It is the driving and checking end of that block's interface.
- Generates an exhaustive operand sweep on the adder's a_in/b_in/cin_in.
- Re-aligns the expected result through a latency-matched delay line, then compares against the adder's registered sum_out/cout_out.
- Reports pass/fail, an error count and the first failing vector. Sits beside the adder in the verification top level.

Parameters:
- WIDTH, 4, operand width of the adder under test.
- LATENCY, 3, clock edges from the edge that launches a vector to the edge that samples its result (checker output reg + 2 adder reg stages).
- ERR_W, 16, width of err_count.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- a_out  output  WIDTH  operand A to adder a_in (registered).
- b_out  output  WIDTH  operand B to adder b_in (registered).
- cin_out  output  1  carry-in to adder cin_in (registered).
- sum_in  input  WIDTH  adder sum_out.
- cout_in  input  1  adder cout_out.
- busy  output  1  high in DRIVE and DRAIN.
- done  output  1  sweep complete; held until next start or reset.
- pass  output  1  valid when done: err_count == 0.
- err_count  output  ERR_W  mismatching vectors; saturates at all-ones.
- first_fail_valid  output  1  at least one mismatch recorded.
- first_fail_vec  output  2*WIDTH+1  vector index of the first mismatch.

Behaviour:
- Reset (clear=0, async): state IDLE. All outputs 0: a_out, b_out, cin_out, busy, done, pass, err_count, first_fail_*. Delay line valid bits cleared. Reset mid-sweep aborts the sweep with no partial results kept.
- Vector index v has 2*WIDTH+1 bits. Mapping: a=v[2W:W+1], b=v[W:1], cin=v[0]. Expected value = a+b+cin, computed WIDTH+1 bits wide; MSB is the expected cout.
- FSM states: IDLE, DRIVE, DRAIN, DONE.
- IDLE, start=1 -> DRIVE. Vector 0 is launched on the same edge.
- DRIVE launches one vector per edge, v = 0 .. 2^(2W+1)-1. After the last vector -> DRAIN; operands return to 0.
- DRAIN lasts LATENCY-1 edges, until the last compare has occurred, then -> DONE.
- DONE, start=1 -> DRIVE. This clears err_count and first_fail_* and launches vector 0 on that edge.
- start is ignored in DRIVE and DRAIN.
- In IDLE, DRAIN and DONE: a_out=b_out=cin_out=0.
- Delay line has LATENCY stages of {valid, v, expected}. Stage 0 is loaded on each launch edge.
- The result for the vector launched at edge t is compared at edge t+LATENCY against {cout_in, sum_in}.
- On mismatch with valid=1: err_count increments (saturating). If first_fail_valid=0, first_fail_vec<=v and first_fail_valid<=1.
- Compares occur only when the tail valid bit is 1; values seen during IDLE, DONE or the pipeline fill are ignored.
- done rises on the edge entering DONE. pass is registered in the same edge as done. Both drop when leaving DONE.
- Default sweep: 512 vectors. done is high after edge s+512+LATENCY-1 relative to start edge s, i.e. 514 edges after s for LATENCY=3.

Decomposition:
- Shared package adder_bist_pkg holds:
  - state enum {IDLE, DRIVE, DRAIN, DONE};
  - default WIDTH and LATENCY constants;
  - function exp_sum(a,b,cin) returning WIDTH+1 bits.
- One natural sub-module: adder_bist_pipe. It is the parameterised LATENCY-deep delay line of {valid, v, expected} with async active-low clear.

Test Plan:
- Reset: clear=0 with start=1 and X on sum_in -> all outputs 0, state IDLE; holds after clear=1 with start=0.
- Golden run: fault-free registered adder, pulse start -> busy high 513 edges, done=1, pass=1, err_count=0, first_fail_valid=0.
- Stuck-at-0 on sum_in[0] -> err_count=256, first_fail_vec=1 (a=0,b=0,cin=1, expected 1, got 0), pass=0.
- Stuck-at-1 on cout_in -> err_count=256 (vectors with a+b+cin<16), first_fail_vec=0.
- Reset mid-sweep: clear=0 at vector 200 -> immediate IDLE, all outputs 0. A following start gives a full clean 512-vector pass.
- Latency mismatch: LATENCY=2 against the default adder -> pass=0, err_count>0. start pulsed during DRIVE has no effect on the vector sequence.

Source files
------------

// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder BIST checker.
//   state_e  : sweep controller states
//   DEF_*    : default operand width and launch-to-sample latency
//   exp_sum  : reference a+b+cin, one bit wider than the operands
package adder_bist_pkg;

  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_LATENCY = 3;

  // Widest operand the reference function handles; callers zero-extend
  // narrower operands and keep the low WIDTH+1 bits of the result.
  localparam int unsigned MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [MAX_W:0] exp_sum(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/adder_bist_pipe.sv
// LATENCY-deep delay line of {valid, vector index, expected result}.
// Stage 0 loads every edge; the tail lines up with the adder's registered
// result for the same vector.
//   clk, clear      : clock, asynchronous active-low clear
//   in_valid/vec/exp: launched vector and its expected result
//   out_valid/vec/exp: tail stage, aligned with the adder output
module adder_bist_pipe #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned VW      = 9,
  parameter int unsigned EW      = 5
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [VW-1:0] in_vec,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  output logic [VW-1:0] out_vec,
  output logic [EW-1:0] out_exp
);

  logic          valid_q [LATENCY];
  logic          valid_d [LATENCY];
  logic [VW-1:0] vec_q   [LATENCY];
  logic [VW-1:0] vec_d   [LATENCY];
  logic [EW-1:0] exp_q   [LATENCY];
  logic [EW-1:0] exp_d   [LATENCY];

  always_comb begin
    valid_d[0] = in_valid;
    vec_d[0]   = in_vec;
    exp_d[0]   = in_exp;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      vec_d[i]   = vec_q[i-1];
      exp_d[i]   = exp_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        valid_q[i] <= 1'b0;
        vec_q[i]   <= '0;
        exp_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        valid_q[i] <= valid_d[i];
        vec_q[i]   <= vec_d[i];
        exp_q[i]   <= exp_d[i];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_vec   = vec_q[LATENCY-1];
  assign out_exp   = exp_q[LATENCY-1];

endmodule

// File: rtl/adder_bist_checker.sv
// Built-in self-test engine for the registered carry-lookahead adder.
// Sweeps every {a, b, cin} combination, delays the expected result to line
// up with the adder output, and records mismatches.
//   clk, clear          : clock, asynchronous active-low reset
//   start               : begin a sweep (honoured in IDLE and DONE only)
//   a_out/b_out/cin_out : registered operands to the adder
//   sum_in/cout_in      : registered adder result
//   busy                : sweep or drain in progress
//   done, pass          : sweep complete / no mismatches seen
//   err_count           : saturating mismatch count
//   first_fail_valid/vec: index of the first mismatching vector
// LATENCY must be at least 2 (the drain phase lasts LATENCY-1 edges).
module adder_bist_checker
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned ERR_W   = 16
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic               cin_out,
  input  logic [WIDTH-1:0]   sum_in,
  input  logic               cout_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic               first_fail_valid,
  output logic [2*WIDTH:0]   first_fail_vec
);

  localparam int unsigned VW = 2 * WIDTH + 1;
  localparam int unsigned EW = WIDTH + 1;
  localparam int unsigned DW = $clog2(LATENCY) + 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LATENCY - 2);

  state_e           state_q, state_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [VW-1:0]    ffvec_q, ffvec_d;

  logic             launch;
  logic [VW-1:0]    launch_vec;
  logic [EW-1:0]    launch_exp;
  logic             tail_valid;
  logic [VW-1:0]    tail_vec;
  logic [EW-1:0]    tail_exp;

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    ffv_d      = ffv_q;
    ffvec_d    = ffvec_q;
    launch     = 1'b0;
    launch_vec = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          launch  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
        end
      end
      DRIVE: begin
        // vec_q holds the last launched index; stop once the top one is out.
        if (vec_q == '1) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          launch     = 1'b1;
          launch_vec = vec_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    vec_d = launch ? launch_vec : vec_q;

    if (launch) begin
      a_d   = launch_vec[2*WIDTH:WIDTH+1];
      b_d   = launch_vec[WIDTH:1];
      cin_d = launch_vec[0];
    end else begin
      a_d   = '0;
      b_d   = '0;
      cin_d = 1'b0;
    end

    launch_exp = EW'(exp_sum(MAX_W'(a_d), MAX_W'(b_d), cin_d));

    if (tail_valid && ({cout_in, sum_in} != tail_exp)) begin
      if (err_d != '1) err_d = err_d + 1'b1;
      if (!ffv_d) begin
        ffv_d   = 1'b1;
        ffvec_d = tail_vec;
      end
    end

    // The final compare lands on the same edge that enters DONE, so pass
    // must see the post-compare count.
    if (state_q == DRAIN && state_d == DONE) pass_d = (err_d == '0);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      vec_q   <= '0;
      drain_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      drain_q <= drain_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  adder_bist_pipe #(
    .LATENCY (LATENCY),
    .VW      (VW),
    .EW      (EW)
  ) u_pipe (
    .clk       (clk),
    .clear     (clear),
    .in_valid  (launch),
    .in_vec    (vec_d),
    .in_exp    (launch_exp),
    .out_valid (tail_valid),
    .out_vec   (tail_vec),
    .out_exp   (tail_exp)
  );

  assign a_out            = a_q;
  assign b_out            = b_q;
  assign cin_out          = cin_q;
  assign busy             = (state_q == DRIVE) || (state_q == DRAIN);
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: a two-stage registered adder model (with
// selectable stuck-at faults) closes the loop; expected sweep results are
// queued when a sweep is started and popped by a monitor when done rises.
module tb_adder_bist_checker;

  localparam int W = 4;

  typedef struct {
    int   edges;
    logic pass;
    int   err;
    logic ffv;
    int   ffvec;
  } exp_t;

  logic clk = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic x_mode = 1'b1;
  int   fault = 0;

  always #5 clk = ~clk;

  // DUT 1: default latency
  logic [W-1:0] a1, b1, sum1;
  logic         cin1, cout1, busy1, done1, pass1, ffv1;
  logic [15:0]  err1;
  logic [2*W:0] ffvec1;
  logic [W:0]   s1a = '0, s1b = '0;

  always @(posedge clk) begin
    s1a <= {1'b0, a1} + {1'b0, b1} + {{W{1'b0}}, cin1};
    s1b <= s1a;
  end
  assign sum1  = x_mode ? 'x : (fault == 1 ? {s1b[W-1:1], 1'b0} : s1b[W-1:0]);
  assign cout1 = x_mode ? 1'bx : (fault == 2 ? 1'b1 : s1b[W]);

  adder_bist_checker dut (
    .clk(clk), .clear(clear), .start(start),
    .a_out(a1), .b_out(b1), .cin_out(cin1),
    .sum_in(sum1), .cout_in(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  // DUT 2: latency set one short of the adder's real latency
  logic [W-1:0] a2, b2, sum2;
  logic         cin2, cout2, busy2, done2, pass2, ffv2;
  logic [15:0]  err2;
  logic [2*W:0] ffvec2;
  logic [W:0]   s2a = '0, s2b = '0;

  always @(posedge clk) begin
    s2a <= {1'b0, a2} + {1'b0, b2} + {{W{1'b0}}, cin2};
    s2b <= s2a;
  end
  assign sum2  = s2b[W-1:0];
  assign cout2 = s2b[W];

  adder_bist_checker #(.LATENCY(2)) dut2 (
    .clk(clk), .clear(clear), .start(start2),
    .a_out(a2), .b_out(b2), .cin_out(cin2),
    .sum_in(sum2), .cout_in(cout2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc1 = 0;
  int start_cyc2 = 0;
  exp_t q1[$];
  exp_t q2[$];
  logic done1_prev = 1'b0;
  logic done2_prev = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic sb_compare(input string tag, input exp_t e, input int edges,
                            input logic p, input int ec, input logic fv, input int fvec);
    chk({tag, "_done_edges"}, edges, e.edges);
    chk({tag, "_pass"}, int'(p), int'(e.pass));
    chk({tag, "_err_count"}, ec, e.err);
    chk({tag, "_ff_valid"}, int'(fv), int'(e.ffv));
    if (e.ffv) chk({tag, "_ff_vec"}, fvec, e.ffvec);
  endtask

  // Monitors: pop an expectation on each rising done.
  always @(negedge clk) begin
    exp_t e;
    if (done1 && !done1_prev) begin
      if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        sb_compare("dut1", e, cyc - start_cyc1, pass1, int'(err1), ffv1, int'(ffvec1));
      end
    end
    if (done2 && !done2_prev) begin
      if (q2.size() == 0) chk("dut2_unexpected_done", 1, 0);
      else begin
        e = q2.pop_front();
        sb_compare("dut2", e, cyc - start_cyc2, pass2, int'(err2), ffv2, int'(ffvec2));
      end
    end
    done1_prev <= done1;
    done2_prev <= done2;
  end

  task automatic check_zero1(input string name);
    chk({name, "_ctrl"}, int'({a1, b1, cin1, busy1, done1, pass1, ffv1}), 0);
    chk({name, "_err"}, int'(err1), 0);
    chk({name, "_ffvec"}, int'(ffvec1), 0);
  endtask

  // Start a sweep on DUT 1, check the launched vector sequence, and wait
  // (bounded) for done. mid_start >= 0 re-pulses start during DRIVE.
  task automatic sweep1(input string name, input exp_t e, input int mid_start);
    int seq_err = 0;
    int n = 0;
    q1.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start_cyc1 = cyc;
    start = 1'b0;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      if ({a1, b1, cin1} != 9'(k) || !busy1) seq_err++;
      start = (k == mid_start);
    end
    chk({name, "_vector_seq"}, seq_err, 0);
    @(negedge clk);
    start = 1'b0;
    chk({name, "_drain_ops"}, int'({a1, b1, cin1, busy1}), 1);
    while (!done1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_timeout"}, int'(done1), 1);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int n;

    // Reset with start high and unknown adder output
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_zero1("reset_active");
    clear = 1'b1;
    start = 1'b0;
    x_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_zero1("reset_release");

    // Golden run
    e = '{edges: 514, pass: 1'b1, err: 0, ffv: 1'b0, ffvec: 0};
    sweep1("golden", e, -1);
    repeat (5) @(negedge clk);
    chk("golden_done_hold", int'({done1, pass1, busy1}), 6);

    // sum_in[0] stuck at 0: every odd sum mismatches, first is v=1
    fault = 1;
    e = '{edges: 514, pass: 1'b0, err: 256, ffv: 1'b1, ffvec: 1};
    sweep1("sum0_sa0", e, -1);

    // cout_in stuck at 1: every sum < 16 mismatches, first is v=0;
    // a start pulse mid-DRIVE must not disturb the sequence
    fault = 2;
    e = '{edges: 514, pass: 1'b0, err: 256, ffv: 1'b1, ffvec: 0};
    sweep1("cout_sa1", e, 100);

    // Reset in the middle of a sweep, at vector 200
    fault = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ({a1, b1, cin1} != 9'd200 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_v200", int'({a1, b1, cin1}), 200);
    #2 clear = 1'b0;
    #1 check_zero1("abort_reset");
    @(negedge clk);
    check_zero1("abort_reset_hold");
    clear = 1'b1;
    @(negedge clk);

    e = '{edges: 514, pass: 1'b1, err: 0, ffv: 1'b0, ffvec: 0};
    sweep1("post_abort", e, -1);

    // LATENCY=2 against the 3-edge adder: each compare sees the previous
    // vector's result. Odd v differ by cin (256), even v with b=0, a>0 (15).
    e = '{edges: 513, pass: 1'b0, err: 271, ffv: 1'b1, ffvec: 1};
    q2.push_back(e);
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start_cyc2 = cyc;
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("lat2_done_timeout", int'(done2), 1);
    @(negedge clk);

    chk("scoreboard_empty", q1.size() + q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
